// File: rtl/vend_ctrl_multi_pkg.sv
// Shared types and constants for the vending controller.
// Holds the FSM state encoding, the accepted note denominations (largest first),
// the bit layout of a 32-bit item table entry, and the note helper functions.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_t;

  localparam int unsigned NUM_DENOM = 7;
  localparam int unsigned DENOMS [NUM_DENOM] = '{100, 50, 20, 10, 5, 2, 1};

  // Table entry layout: {sold, stock, price}
  localparam int unsigned PRICE_LSB = 0;
  localparam int unsigned PRICE_MSB = 15;
  localparam int unsigned STOCK_LSB = 16;
  localparam int unsigned STOCK_MSB = 23;
  localparam int unsigned SOLD_LSB  = 24;
  localparam int unsigned SOLD_MSB  = 31;

  // True when v is one of the accepted denominations.
  function automatic logic is_denom(input int unsigned v);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (DENOMS[i] == v) hit = 1'b1;
    end
    return hit;
  endfunction

  // Largest denomination not exceeding rem; 0 when rem is 0.
  // Walks smallest-first so the last match is the largest one.
  function automatic int unsigned greedy_note(input int unsigned rem);
    int unsigned best;
    best = 0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (DENOMS[NUM_DENOM-1-i] <= rem) best = DENOMS[NUM_DENOM-1-i];
    end
    return best;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Bus bundle between the vending controller and its environment.
// Groups the table config port, note acceptor, keypad, dispenser and change
// handshakes, plus status outputs. slave = controller side, master = environment.
interface vend_ctrl_multi_if #(
  parameter int unsigned K  = 64,
  parameter int unsigned D  = $clog2(K),
  parameter int unsigned N  = 7,
  parameter int unsigned PW = 16
);
  logic          cfg_we;
  logic          cfg_re;
  logic [D-1:0]  cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          cfg_err;
  logic          note_valid;
  logic [N-1:0]  note_val;
  logic          note_reject;
  logic          item_valid;
  logic [D-1:0]  item_code;
  logic          cancel;
  logic          vend_valid;
  logic [D-1:0]  vend_item;
  logic          vend_ready;
  logic          chg_valid;
  logic [N-1:0]  chg_note;
  logic          chg_ready;
  logic [PW-1:0] credit;
  logic          busy;
  logic          sold_out;
  logic          timeout;

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata, note_valid, note_val,
           item_valid, item_code, cancel, vend_ready, chg_ready,
    output cfg_rdata, cfg_err, note_reject, vend_valid, vend_item,
           chg_valid, chg_note, credit, busy, sold_out, timeout
  );

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata, note_valid, note_val,
           item_valid, item_code, cancel, vend_ready, chg_ready,
    input  cfg_rdata, cfg_err, note_reject, vend_valid, vend_item,
           chg_valid, chg_note, credit, busy, sold_out, timeout
  );
endinterface

// File: rtl/vend_ctrl_multi_change_dispenser.sv
// Greedy change dispenser: load captures an amount, then one note at a time is
// offered on chg_valid/chg_note until the remaining amount reaches zero.
// Ports: clk, reset (sync, active-high), load, amount, chg_ready in;
//        chg_valid, chg_note, done (remaining == 0) out.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned N  = 7,
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] amount,
  input  logic          chg_ready,
  output logic          chg_valid,
  output logic [N-1:0]  chg_note,
  output logic          done
);

  logic [PW-1:0] rem_q, rem_d;
  logic          valid_q;
  logic [N-1:0]  note_q;

  always_comb begin
    rem_d = rem_q;
    if (load) begin
      rem_d = amount;
    end else if (valid_q && chg_ready) begin
      rem_d = rem_q - PW'(note_q);
    end
  end

  // valid/note are computed from the next remaining value so a new note is
  // presented the cycle right after a handshake, and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      valid_q <= 1'b0;
      note_q  <= '0;
    end else begin
      rem_q   <= rem_d;
      valid_q <= (rem_d != '0);
      note_q  <= N'(greedy_note(32'(rem_d)));
    end
  end

  assign chg_valid = valid_q;
  assign chg_note  = note_q;
  assign done      = (rem_q == '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending controller top: K-entry item table (price/stock/sold), note collection
// with denomination and ceiling checks, cancel/inactivity refund, and greedy
// change dispensing over a valid/ready handshake.
// Ports: clk, reset (sync, active-high); bus (vend_ctrl_multi_if.slave) carrying
//        config, note, keypad, vend/change handshakes and status outputs.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned K       = 64,
  parameter int unsigned D       = $clog2(K),
  parameter int unsigned N       = 7,
  parameter int unsigned PW      = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned MAX_ACC = 500
) (
  input  logic              clk,
  input  logic              reset,
  vend_ctrl_multi_if.slave  bus
);

  localparam int unsigned AW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [31:0]   tbl_q [K];

  state_t        state_q;
  logic [PW-1:0] acc_q;
  logic [TW-1:0] timer_q;
  logic [D-1:0]  item_q;
  logic [31:0]   entry_q;
  logic [31:0]   cfg_rdata_q;
  logic          cfg_err_q;
  logic          note_reject_q;
  logic          vend_valid_q;
  logic          sold_out_q;
  logic          timeout_q;

  logic [PW-1:0] price;
  logic [AW-1:0] sum;
  logic          note_ok;
  logic          paid;
  logic          accept;
  logic          tmo_hit;
  logic          cfg_ok;
  logic          wb_en;
  logic [31:0]   wb_data;
  logic          disp_load;
  logic [PW-1:0] disp_amt;
  logic          disp_done;

  always_comb begin
    price   = PW'(entry_q[PRICE_MSB:PRICE_LSB]);
    sum     = {1'b0, acc_q} + AW'(bus.note_val);
    note_ok = bus.note_valid && is_denom(32'(bus.note_val)) && (sum <= AW'(MAX_ACC));
    paid    = (acc_q >= price);
    // COLLECT priority: cancel, then payment complete, then note, then timeout.
    accept  = (state_q == COLLECT) && !bus.cancel && !paid && note_ok;
    tmo_hit = (state_q == COLLECT) && !bus.cancel && !paid && !note_ok &&
              (timer_q == TW'(TIMEOUT - 1));
    cfg_ok  = (state_q == IDLE) && !bus.item_valid;
    wb_en   = (state_q == VEND) && bus.vend_ready;

    wb_data = entry_q;
    wb_data[STOCK_MSB:STOCK_LSB] = entry_q[STOCK_MSB:STOCK_LSB] - 8'd1;
    if (entry_q[SOLD_MSB:SOLD_LSB] != 8'hFF) begin
      wb_data[SOLD_MSB:SOLD_LSB] = entry_q[SOLD_MSB:SOLD_LSB] + 8'd1;
    end

    disp_load = wb_en || ((state_q == COLLECT) && (bus.cancel || tmo_hit));
    disp_amt  = (state_q == VEND) ? (acc_q - price) : acc_q;
  end

  // Table storage carries no reset so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.cfg_we && cfg_ok) begin
        tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
      end else if (wb_en) begin
        tbl_q[item_q] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      timer_q       <= '0;
      item_q        <= '0;
      entry_q       <= '0;
      cfg_rdata_q   <= '0;
      cfg_err_q     <= 1'b0;
      note_reject_q <= 1'b0;
      vend_valid_q  <= 1'b0;
      sold_out_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sold_out_q    <= 1'b0;
      timeout_q     <= 1'b0;
      cfg_err_q     <= bus.cfg_we && !cfg_ok;
      note_reject_q <= bus.note_valid && !accept;
      if (bus.cfg_re) cfg_rdata_q <= tbl_q[bus.cfg_addr];

      case (state_q)
        IDLE: begin
          if (bus.item_valid) begin
            item_q  <= bus.item_code;
            entry_q <= tbl_q[bus.item_code];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (entry_q[STOCK_MSB:STOCK_LSB] == 8'd0) begin
            sold_out_q <= 1'b1;
            state_q    <= IDLE;
          end else if (price == '0) begin
            vend_valid_q <= 1'b1;
            state_q      <= VEND;
          end else begin
            timer_q <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.cancel) begin
            state_q <= REFUND;
          end else if (paid) begin
            vend_valid_q <= 1'b1;
            state_q      <= VEND;
          end else if (note_ok) begin
            acc_q   <= sum[PW-1:0];
            timer_q <= '0;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= REFUND;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        VEND: begin
          if (bus.vend_ready) begin
            vend_valid_q <= 1'b0;
            state_q      <= CHANGE;
          end
        end
        CHANGE, REFUND: begin
          if (disp_done) begin
            acc_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  change_dispenser #(
    .N  (N),
    .PW (PW)
  ) u_disp (
    .clk       (clk),
    .reset     (reset),
    .load      (disp_load),
    .amount    (disp_amt),
    .chg_ready (bus.chg_ready),
    .chg_valid (bus.chg_valid),
    .chg_note  (bus.chg_note),
    .done      (disp_done)
  );

  assign bus.cfg_rdata   = cfg_rdata_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.note_reject = note_reject_q;
  assign bus.vend_valid  = vend_valid_q;
  assign bus.vend_item   = item_q;
  assign bus.credit      = acc_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sold_out    = sold_out_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed self-checking bench for vend_ctrl_multi.
module tb_vend_ctrl_multi;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.K(64), .N(7), .PW(16)) bus ();

  vend_ctrl_multi #(
    .K(64), .N(7), .PW(16), .TIMEOUT(1000), .MAX_ACC(500)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int exp_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick;
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
    bus.cfg_re = 1'b1; bus.cfg_addr = a;
    tick;
    bus.cfg_re = 1'b0;
    d = bus.cfg_rdata;
  endtask

  task automatic select(input logic [5:0] c);
    bus.item_valid = 1'b1; bus.item_code = c;
    tick;
    bus.item_valid = 1'b0;
  endtask

  task automatic note(input logic [6:0] v);
    bus.note_valid = 1'b1; bus.note_val = v;
    tick;
    bus.note_valid = 1'b0;
  endtask

  task automatic wait_vend(input string tag);
    int cyc = 0;
    while (!bus.vend_valid && cyc < 10) begin tick; cyc++; end
    chk(tag, 32'(bus.vend_valid), 32'd1);
  endtask

  // Accept change notes one by one and compare against exp_q.
  task automatic run_change(input string tag);
    int got [$];
    int cyc = 0;
    got = {};
    while (bus.busy && cyc < 200) begin
      if (bus.chg_valid) begin
        got.push_back(int'(bus.chg_note));
        bus.chg_ready = 1'b1;
        tick;
        bus.chg_ready = 1'b0;
      end else begin
        tick;
      end
      cyc++;
    end
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_note%0d", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_credit"}, 32'(bus.credit), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;

    reset = 1'b1;
    bus.cfg_we = 0; bus.cfg_re = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.note_valid = 0; bus.note_val = '0; bus.item_valid = 0; bus.item_code = '0;
    bus.cancel = 0; bus.vend_ready = 0; bus.chg_ready = 0;
    tick; tick;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_vend_valid", 32'(bus.vend_valid), 32'd0);
    chk("rst_chg_valid", 32'(bus.chg_valid), 32'd0);
    chk("rst_credit", 32'(bus.credit), 32'd0);
    reset = 1'b0;
    tick;

    cfg_write(6'd3,  32'h0005_0023);   // price 35, stock 5
    chk("cfg_err_idle", 32'(bus.cfg_err), 32'd0);
    cfg_write(6'd7,  32'h0000_0032);   // stock 0
    cfg_write(6'd10, 32'h0009_0064);   // price 100
    cfg_write(6'd11, 32'h0009_003C);   // price 60
    cfg_write(6'd12, 32'h0009_0001);   // price 1
    cfg_write(6'd13, 32'h0001_0258);   // price 600
    cfg_read(6'd3, rd);
    chk("rd_slot3_init", rd, 32'h0005_0023);

    // Purchase item 3 with 20+20, change 5
    select(6'd3);
    chk("s1_busy", 32'(bus.busy), 32'd1);
    tick;
    note(7'd20);
    chk("s1_credit20", 32'(bus.credit), 32'd20);
    note(7'd20);
    chk("s1_credit40", 32'(bus.credit), 32'd40);
    wait_vend("s1_vend_valid");
    chk("s1_vend_item", 32'(bus.vend_item), 32'd3);
    tick;
    chk("s1_vend_hold", 32'(bus.vend_valid), 32'd1);
    bus.vend_ready = 1'b1; tick; bus.vend_ready = 1'b0;
    chk("s1_vend_drop", 32'(bus.vend_valid), 32'd0);
    exp_q = '{5};
    run_change("s1_chg");
    cfg_read(6'd3, rd);
    chk("s1_slot3_wb", rd, 32'h0104_0023);

    // Sold out
    select(6'd7);
    chk("s2_sold_out_early", 32'(bus.sold_out), 32'd0);
    tick;
    chk("s2_sold_out", 32'(bus.sold_out), 32'd1);
    chk("s2_no_vend", 32'(bus.vend_valid), 32'd0);
    tick;
    chk("s2_sold_out_pulse", 32'(bus.sold_out), 32'd0);
    chk("s2_idle", 32'(bus.busy), 32'd0);

    // Cancel with simultaneous note
    select(6'd10); tick;
    note(7'd50); note(7'd20);
    chk("s3_credit70", 32'(bus.credit), 32'd70);
    bus.cancel = 1'b1; bus.note_valid = 1'b1; bus.note_val = 7'd10;
    tick;
    bus.cancel = 1'b0; bus.note_valid = 1'b0;
    chk("s3_reject10", 32'(bus.note_reject), 32'd1);
    chk("s3_credit_kept", 32'(bus.credit), 32'd70);
    exp_q = '{50, 20};
    run_change("s3_refund");

    // Inactivity timeout
    select(6'd11); tick;
    note(7'd10);
    cyc = 0;
    while (!bus.timeout && cyc < 1100) begin tick; cyc++; end
    chk("s4_timeout", 32'(bus.timeout), 32'd1);
    chk("s4_timeout_cycles", 32'(cyc), 32'd1000);
    exp_q = '{10};
    run_change("s4_refund");

    // Large change with stalled chg_ready
    select(6'd12); tick;
    note(7'd100);
    wait_vend("s5_vend_valid");
    bus.vend_ready = 1'b1; tick; bus.vend_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s5_stall_valid%0d", i), 32'(bus.chg_valid), 32'd1);
      chk($sformatf("s5_stall_note%0d", i), 32'(bus.chg_note), 32'd50);
      tick;
    end
    exp_q = '{50, 20, 20, 5, 2, 2};
    run_change("s5_chg");
    cfg_read(6'd12, rd);
    chk("s5_slot12_wb", rd, 32'h0108_0001);

    // Rejects, ceiling, cfg_err in COLLECT
    select(6'd13); tick;
    note(7'd3);
    chk("s6_reject3", 32'(bus.note_reject), 32'd1);
    chk("s6_credit0", 32'(bus.credit), 32'd0);
    for (int i = 0; i < 5; i++) note(7'd100);
    chk("s6_credit500", 32'(bus.credit), 32'd500);
    note(7'd1);
    chk("s6_reject_max", 32'(bus.note_reject), 32'd1);
    chk("s6_credit_max", 32'(bus.credit), 32'd500);
    cfg_write(6'd13, 32'h0000_0000);
    chk("s6_cfg_err", 32'(bus.cfg_err), 32'd1);
    bus.cancel = 1'b1; tick; bus.cancel = 1'b0;
    exp_q = '{100, 100, 100, 100, 100};
    run_change("s6_refund");
    cfg_read(6'd13, rd);
    chk("s6_slot13_kept", rd, 32'h0001_0258);

    // Reset during CHANGE
    select(6'd12); tick;
    note(7'd100);
    wait_vend("s7_vend_valid");
    bus.vend_ready = 1'b1; tick; bus.vend_ready = 1'b0;
    chk("s7_in_change", 32'(bus.chg_valid), 32'd1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("s7_rst_busy", 32'(bus.busy), 32'd0);
    chk("s7_rst_chg_valid", 32'(bus.chg_valid), 32'd0);
    chk("s7_rst_credit", 32'(bus.credit), 32'd0);
    chk("s7_rst_vend_valid", 32'(bus.vend_valid), 32'd0);
    tick;
    chk("s7_rst_chg_stays", 32'(bus.chg_valid), 32'd0);
    cfg_read(6'd12, rd);
    chk("s7_slot12_kept", rd, 32'h0207_0001);
    cfg_read(6'd3, rd);
    chk("s7_slot3_kept", rd, 32'h0104_0023);
    note(7'd5);
    chk("s7_idle_reject", 32'(bus.note_reject), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
